// File: rtl/computer.sv
// Hack-ISA single-cycle 16-bit computer.
// It contains the program ROM, the A/D registers, the ALU, the data RAM and the PC.
// Programs are loaded by hierarchical writes into ROM.mem[].
// progCounter and instruction are observed hierarchically.

// Program store: the read is combinational and word-addressed.
// The write port exists only so that mem has a structural driver. The top ties it
// off, so contents change only through hierarchical assignment.
module computer_rom #(
  parameter int AddrSize = 15,
  parameter int WordSize = 16
) (
  input  logic                clk,
  input  logic                load_en,
  input  logic [AddrSize-1:0] load_addr,
  input  logic [WordSize-1:0] load_data,
  input  logic [AddrSize-1:0] addr,
  output logic [WordSize-1:0] data
);

  logic [WordSize-1:0] mem [0:2**AddrSize-1];

  // Optional word load (held inactive by the top level)
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  assign data = mem[addr];

endmodule

module computer #(
  parameter int MemAndIOAddrSize = 15,
  parameter int ProgAddrSize     = 15,
  parameter int WordSize         = 16
) (
  input logic reset,
  input logic clk
);

  localparam logic [ProgAddrSize-1:0] PcStep = {{(ProgAddrSize-1){1'b0}}, 1'b1};

  logic [ProgAddrSize-1:0] progCounter;
  logic [WordSize-1:0]     instruction;
  logic [WordSize-1:0]     a_reg;
  logic [WordSize-1:0]     d_reg;
  logic [WordSize-1:0]     ram [0:2**MemAndIOAddrSize-1];

  logic                    is_c;
  logic                    sel_m;
  logic                    zx, nx, zy, ny, fn, no;
  logic [2:0]              dest;
  logic [2:0]              jmp;
  logic [WordSize-1:0]     m_in;
  logic [WordSize-1:0]     alu_x;
  logic [WordSize-1:0]     alu_y;
  logic [WordSize-1:0]     alu_o;
  logic                    zr;
  logic                    ng;
  logic                    jump_taken;
  logic [ProgAddrSize-1:0] pc_next;
  logic [WordSize-1:0]     a_next;
  logic [WordSize-1:0]     d_next;
  logic                    ram_we;
  logic                    unused_bits;

  computer_rom #(
    .AddrSize (ProgAddrSize),
    .WordSize (WordSize)
  ) ROM (
    .clk       (clk),
    .load_en   (1'b0),
    .load_addr ('0),
    .load_data ('0),
    .addr      (progCounter),
    .data      (instruction)
  );

  // Field decode of the current instruction; bits 14:13 of a C-instruction carry no meaning
  assign is_c        = instruction[WordSize-1];
  assign sel_m       = instruction[12];
  assign zx          = instruction[11];
  assign nx          = instruction[10];
  assign zy          = instruction[9];
  assign ny          = instruction[8];
  assign fn          = instruction[7];
  assign no          = instruction[6];
  assign dest        = instruction[5:3];
  assign jmp         = instruction[2:0];
  assign unused_bits = ^instruction[14:13];

  // The RAM read is asynchronous and indexed by the low bits of A
  assign m_in = ram[a_reg[MemAndIOAddrSize-1:0]];

  // ALU: pre-condition x and y, then add or AND, then optionally invert the result
  always_comb begin
    alu_x = d_reg;
    alu_y = sel_m ? m_in : a_reg;
    alu_o = '0;
    if (zx) alu_x = '0;
    if (nx) alu_x = ~alu_x;
    if (zy) alu_y = '0;
    if (ny) alu_y = ~alu_y;
    alu_o = fn ? (alu_x + alu_y) : (alu_x & alu_y);
    if (no) alu_o = ~alu_o;
  end

  assign zr = (alu_o == '0);
  assign ng = alu_o[WordSize-1];

  // Jump decision and next-state selection; both use A from before the edge
  always_comb begin
    jump_taken = is_c & ((jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr));
    pc_next    = jump_taken ? a_reg[ProgAddrSize-1:0] : progCounter + PcStep;
    a_next     = a_reg;
    d_next     = d_reg;
    ram_we     = 1'b0;
    if (!is_c) begin
      a_next = {1'b0, instruction[WordSize-2:0]};
    end else begin
      if (dest[2]) a_next = alu_o;
      if (dest[1]) d_next = alu_o;
      ram_we = dest[0];
    end
  end

  // PC/A/D commit; reset clears them immediately, without waiting for a clock edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      progCounter <= '0;
      a_reg       <= '0;
      d_reg       <= '0;
    end else begin
      progCounter <= pc_next;
      a_reg       <= a_next;
      d_reg       <= d_next;
    end
  end

  // RAM write at the pre-edge A address; RAM is not cleared by reset but is frozen while reset is held
  always_ff @(posedge clk) begin
    if (!reset && ram_we) ram[a_reg[MemAndIOAddrSize-1:0]] <= alu_o;
  end

endmodule

// File: tb/tb_computer.sv
// Bench for the Hack computer: directed program checks plus random programs
// compared against an instruction-level interpreter of the ISA.
module tb_computer;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  computer dut (.reset(reset), .clk(clk));
  computer #(.MemAndIOAddrSize(4), .ProgAddrSize(4)) dut_w (.reset(reset), .clk(clk));

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m_rom [0:32767];
  logic [15:0] m_ram [int];
  logic [15:0] m_a;
  logic [15:0] m_d;
  logic [14:0] m_pc;
  logic        m_wr;
  int          m_wr_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int addr, input logic [15:0] v);
    dut.ROM.mem[addr] = v;
    m_rom[addr] = v;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32768; i++) begin
      dut.ROM.mem[i] = 16'h0000;
      m_rom[i] = 16'h0000;
    end
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 32768; i++) dut.ram[i] = 16'h0000;
    m_ram.delete();
  endtask

  // Reset is raised between edges and must clear the PC at once; one edge is then taken while reset is still held
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_pc_now", {17'b0, dut.progCounter}, 32'd0);
    chk("rst_a_now", {16'b0, dut.a_reg}, 32'd0);
    chk("rst_d_now", {16'b0, dut.d_reg}, 32'd0);
    tick();
    chk("rst_pc_hold", {17'b0, dut.progCounter}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_pc = '0;
    m_a  = '0;
    m_d  = '0;
  endtask

  function automatic logic [15:0] m_rd(input logic [14:0] addr);
    int k;
    k = int'(addr);
    return m_ram.exists(k) ? m_ram[k] : 16'h0000;
  endfunction

  // Interpreter for one instruction of the ISA
  task automatic model_step();
    logic [15:0] ins, x, y, o, a_old;
    logic        zr, ng, take;
    ins  = m_rom[m_pc];
    m_wr = 1'b0;
    if (!ins[15]) begin
      m_a  = {1'b0, ins[14:0]};
      m_pc = m_pc + 15'd1;
    end else begin
      x = m_d;
      y = ins[12] ? m_rd(m_a[14:0]) : m_a;
      if (ins[11]) x = 16'h0000;
      if (ins[10]) x = ~x;
      if (ins[9])  y = 16'h0000;
      if (ins[8])  y = ~y;
      o = ins[7] ? 16'(x + y) : (x & y);
      if (ins[6]) o = ~o;
      zr   = (o == 16'h0000);
      ng   = o[15];
      take = (ins[2] && ng) || (ins[1] && zr) || (ins[0] && !ng && !zr);
      a_old = m_a;
      if (ins[5]) m_a = o;
      if (ins[4]) m_d = o;
      if (ins[3]) begin
        m_wr_addr = int'(a_old[14:0]);
        m_ram[m_wr_addr] = o;
        m_wr = 1'b1;
      end
      m_pc = take ? a_old[14:0] : m_pc + 15'd1;
    end
  endtask

  initial begin
    int exp_loop [10];
    logic [15:0] ins;

    for (int i = 0; i < 16; i++) begin
      dut_w.ROM.mem[i] = 16'h0000;
      dut_w.ram[i] = 16'h0000;
    end
    clear_rom();
    clear_ram();

    // Reset behaviour and a free-running zero ROM, including the 4-bit PC wrap
    #12;
    reset = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_rst_pc", {17'b0, dut.progCounter}, 32'd3);
    do_reset();
    for (int i = 1; i <= 18; i++) begin
      tick();
      chk("seq_pc", {17'b0, dut.progCounter}, 32'(i));
      chk("wrap_pc", {28'b0, dut_w.progCounter}, 32'(i % 16));
    end

    // Unconditional jump loop
    put(3, 16'h0001);
    put(4, 16'hE007);
    do_reset();
    exp_loop = '{1, 2, 3, 4, 1, 2, 3, 4, 1, 2};
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("loop_pc", {17'b0, dut.progCounter}, 32'(exp_loop[i]));
      if (exp_loop[i] == 4) chk("loop_instr", {16'b0, dut.instruction}, 32'h0000_E007);
    end

    // ALU and destination writes: D=5+3, then M[10]=D
    clear_rom();
    put(0, 16'h0005);
    put(1, 16'hEC10);
    put(2, 16'h0003);
    put(3, 16'hE090);
    put(4, 16'h000A);
    put(5, 16'hE308);
    do_reset();
    tick();
    tick();
    chk("alu_d_eq_a", {16'b0, dut.d_reg}, 32'd5);
    tick();
    tick();
    chk("alu_d_sum", {16'b0, dut.d_reg}, 32'd8);
    tick();
    tick();
    chk("alu_ram10", {16'b0, dut.ram[10]}, 32'd8);
    chk("alu_pc", {17'b0, dut.progCounter}, 32'd6);

    // Conditional jump: JEQ is taken when D=0 and falls through when D=1
    clear_rom();
    put(0, 16'hEA90);
    put(1, 16'h0007);
    put(2, 16'hE302);
    do_reset();
    tick();
    chk("jeq_d0", {16'b0, dut.d_reg}, 32'd0);
    tick();
    tick();
    chk("jeq_taken_pc", {17'b0, dut.progCounter}, 32'd7);
    put(0, 16'hEFD0);
    do_reset();
    tick();
    chk("jeq_d1", {16'b0, dut.d_reg}, 32'd1);
    tick();
    tick();
    chk("jeq_not_taken_pc", {17'b0, dut.progCounter}, 32'd3);

    // Random programs against the interpreter
    for (int p = 0; p < 4; p++) begin
      clear_rom();
      clear_ram();
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 1) == 0) begin
          ins = (p == 3 && $urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 32767))
                                                       : 16'($urandom_range(0, 63));
        end else begin
          ins = {3'b111, 13'($urandom)};
        end
        put(i, ins);
      end
      do_reset();
      for (int c = 0; c < 150; c++) begin
        chk("rnd_instr", {16'b0, dut.instruction}, {16'b0, m_rom[m_pc]});
        model_step();
        tick();
        chk("rnd_pc", {17'b0, dut.progCounter}, {17'b0, m_pc});
        chk("rnd_a", {16'b0, dut.a_reg}, {16'b0, m_a});
        chk("rnd_d", {16'b0, dut.d_reg}, {16'b0, m_d});
        if (m_wr) chk("rnd_ram", {16'b0, dut.ram[m_wr_addr]}, {16'b0, m_ram[m_wr_addr]});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
